// File: rtl/valid_ready_stream_checker.sv
// Receiving end of the 4-bit valid/ready demo stream: applies a back-pressure policy,
// checks accepted words against a fixed permutation and keeps transfer/error statistics.
module valid_ready_stream_checker #(
  parameter int          w_cnt     = 8,
  parameter logic [15:0] lfsr_seed = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             down_valid,
  output logic             down_ready,
  input  logic [3:0]       down_data,
  input  logic             start,
  input  logic             clear,
  input  logic             stop_on_error,
  input  logic [1:0]       ready_mode,
  input  logic             ext_ready,
  output logic [1:0]       state,
  output logic [w_cnt-1:0] rx_count,
  output logic [w_cnt-1:0] err_count,
  output logic             err_flag,
  output logic [w_cnt-1:0] first_err_index,
  output logic [3:0]       expected_data,
  output logic [3:0]       last_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam logic [w_cnt-1:0] CNT_ONE = {{(w_cnt-1){1'b0}}, 1'b1};

  state_t      state_q;
  state_t      state_d;
  logic [3:0]  idx_q;
  logic [15:0] lfsr_q;
  logic        lfsr_fb;
  logic        alt_q;
  logic        alt_d;
  logic        ready_d;
  logic        xfer;
  logic        mismatch;
  logic [3:0]  exp_word;

  always_comb begin
    exp_word = 4'h2;
    case (idx_q)
      4'd0:  exp_word = 4'h2;
      4'd1:  exp_word = 4'h6;
      4'd2:  exp_word = 4'hd;
      4'd3:  exp_word = 4'hb;
      4'd4:  exp_word = 4'h7;
      4'd5:  exp_word = 4'he;
      4'd6:  exp_word = 4'hc;
      4'd7:  exp_word = 4'h4;
      4'd8:  exp_word = 4'h1;
      4'd9:  exp_word = 4'h0;
      4'd10: exp_word = 4'h9;
      4'd11: exp_word = 4'ha;
      4'd12: exp_word = 4'hf;
      4'd13: exp_word = 4'h5;
      4'd14: exp_word = 4'h8;
      default: exp_word = 4'h3;
    endcase
  end

  assign expected_data = exp_word;
  assign state         = state_q;

  // A transfer coincident with clear is discarded, never counted.
  assign xfer     = (state_q == RUN) & down_valid & down_ready & ~clear;
  assign mismatch = xfer & (down_data != exp_word);

  // Fibonacci LFSR, taps 16,14,13,11.
  assign lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start) state_d = RUN;
        RUN:     if (mismatch && stop_on_error) state_d = HALT;
        default: state_d = state_q;
      endcase
    end
  end

  // Ready is decided against the next state, so leaving RUN drops it on the very next edge.
  always_comb begin
    ready_d = 1'b0;
    alt_d   = 1'b0;
    if (state_d == RUN) begin
      case (ready_mode)
        2'd0: ready_d = 1'b1;
        2'd1: ready_d = ext_ready;
        2'd2: ready_d = lfsr_q[0];
        default: begin
          ready_d = ~alt_q;
          alt_d   = ~alt_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      down_ready      <= 1'b0;
      lfsr_q          <= lfsr_seed;
      alt_q           <= 1'b0;
      idx_q           <= 4'd0;
      rx_count        <= '0;
      err_count       <= '0;
      err_flag        <= 1'b0;
      first_err_index <= '0;
      last_data       <= 4'h0;
    end else begin
      state_q    <= state_d;
      down_ready <= ready_d;
      lfsr_q     <= {lfsr_fb, lfsr_q[15:1]};
      alt_q      <= alt_d;
      if (clear) begin
        idx_q           <= 4'd0;
        rx_count        <= '0;
        err_count       <= '0;
        err_flag        <= 1'b0;
        first_err_index <= '0;
        last_data       <= 4'h0;
      end else if (xfer) begin
        last_data <= down_data;
        rx_count  <= rx_count + CNT_ONE;
        idx_q     <= idx_q + 4'd1;
        if (mismatch) begin
          if (err_count != '1) err_count <= err_count + CNT_ONE;
          if (!err_flag) begin
            first_err_index <= rx_count;
            err_flag        <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_valid_ready_stream_checker.sv
// Bench for valid_ready_stream_checker: two widths (8 and 4) driven in parallel and
// compared each cycle against a behavioural model, plus directed literal checks.
module tb_valid_ready_stream_checker;

  localparam logic [15:0] SEED = 16'hACE1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       down_valid = 1'b0;
  logic [3:0] down_data = 4'h0;
  logic       start = 1'b0;
  logic       clear = 1'b0;
  logic       stop_on_error = 1'b0;
  logic [1:0] ready_mode = 2'd0;
  logic       ext_ready = 1'b0;

  logic       ready_a, ready_b;
  logic [1:0] state_a, state_b;
  logic [7:0] rx_a, err_a, first_a;
  logic [3:0] rx_b, err_b, first_b;
  logic       flag_a, flag_b;
  logic [3:0] expd_a, expd_b, last_a, last_b;

  valid_ready_stream_checker #(.w_cnt(8), .lfsr_seed(SEED)) dut_a (
    .clk(clk), .rst_n(rst_n), .down_valid(down_valid), .down_ready(ready_a),
    .down_data(down_data), .start(start), .clear(clear), .stop_on_error(stop_on_error),
    .ready_mode(ready_mode), .ext_ready(ext_ready), .state(state_a), .rx_count(rx_a),
    .err_count(err_a), .err_flag(flag_a), .first_err_index(first_a),
    .expected_data(expd_a), .last_data(last_a)
  );

  valid_ready_stream_checker #(.w_cnt(4), .lfsr_seed(SEED)) dut_b (
    .clk(clk), .rst_n(rst_n), .down_valid(down_valid), .down_ready(ready_b),
    .down_data(down_data), .start(start), .clear(clear), .stop_on_error(stop_on_error),
    .ready_mode(ready_mode), .ext_ready(ext_ready), .state(state_b), .rx_count(rx_b),
    .err_count(err_b), .err_flag(flag_b), .first_err_index(first_b),
    .expected_data(expd_b), .last_data(last_b)
  );

  int checks = 0;
  int errors = 0;

  logic [3:0] seq_t [16] = '{4'h2, 4'h6, 4'hd, 4'hb, 4'h7, 4'he, 4'hc, 4'h4,
                             4'h1, 4'h0, 4'h9, 4'ha, 4'hf, 4'h5, 4'h8, 4'h3};

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int         m_state;      // 0 idle, 1 run, 2 halt
  bit         m_ready;
  int         m_rx, m_err, m_first, m_idx, m_alt_n;
  bit         m_flag, m_xfer;
  logic [3:0] m_last;
  int unsigned m_lfsr;
  logic [3:0] exp_q[$];     // accepted words, in acceptance order

  always @(posedge clk or negedge rst_n) begin
    int  ns;
    bit  mis;
    bit  fb;
    if (!rst_n) begin
      m_state = 0; m_ready = 0; m_rx = 0; m_err = 0; m_first = 0; m_idx = 0;
      m_alt_n = 0; m_flag = 0; m_xfer = 0; m_last = 0; m_lfsr = SEED;
    end else begin
      m_xfer = (m_state == 1) && down_valid && m_ready && !clear;
      mis    = m_xfer && (down_data != seq_t[m_idx]);
      if (clear)                          ns = 0;
      else if (m_state == 0 && start)     ns = 1;
      else if (mis && stop_on_error)      ns = 2;
      else                                ns = m_state;
      if (clear) begin
        m_rx = 0; m_err = 0; m_first = 0; m_flag = 0; m_idx = 0; m_last = 0;
      end else if (m_xfer) begin
        exp_q.push_back(down_data);
        if (mis) begin
          m_err++;
          if (!m_flag) begin
            m_first = m_rx;
            m_flag  = 1;
          end
        end
        m_last = down_data;
        m_rx++;
        m_idx = (m_idx + 1) % 16;
      end
      // Mode 3 gives 1,0,1,0 counted from the first cycle of a run in that mode.
      if (ns != 1) begin
        m_ready = 0; m_alt_n = 0;
      end else if (ready_mode == 2'd3) begin
        m_ready = (m_alt_n % 2) == 0;
        m_alt_n++;
      end else begin
        m_alt_n = 0;
        case (ready_mode)
          2'd0:    m_ready = 1;
          2'd1:    m_ready = ext_ready;
          default: m_ready = m_lfsr[0];
        endcase
      end
      fb     = m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5];
      m_lfsr = (m_lfsr >> 1) | (32'(fb) << 15);
      m_state = ns;
    end
  end

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  // ---------------- per-cycle compare ----------------
  bit cmp_en = 0;
  always @(negedge clk) begin
    if (cmp_en) begin
      check("ready_a", ready_a, m_ready);
      check("ready_b", ready_b, m_ready);
      check("state_a", state_a, m_state);
      check("state_b", state_b, m_state);
      check("rx_a", rx_a, m_rx % 256);
      check("rx_b", rx_b, m_rx % 16);
      check("err_a", err_a, sat(m_err, 255));
      check("err_b", err_b, sat(m_err, 15));
      check("flag_a", flag_a, m_flag);
      check("flag_b", flag_b, m_flag);
      check("first_a", first_a, m_first % 256);
      check("first_b", first_b, m_first % 16);
      check("expd_a", expd_a, seq_t[m_idx]);
      check("expd_b", expd_b, seq_t[m_idx]);
      check("last_a", last_a, m_last);
      check("last_b", last_b, m_last);
    end
  end

  // ---------------- driver ----------------
  logic [3:0] src_q[$];
  bit         gap_en = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    if (m_xfer && src_q.size() > 0) void'(src_q.pop_front());
    if (gap_en && $urandom_range(0, 3) == 0) down_valid = 1'b0;
    else down_valid = (src_q.size() > 0);
    down_data = (src_q.size() > 0) ? src_q[0] : 4'($urandom_range(0, 15));
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic pulse_clear();
    src_q.delete();
    clear = 1'b1; tick(); clear = 1'b0;
  endtask

  task automatic push_seq(input int n, input int bad_k, input logic [3:0] bad_xor);
    for (int k = 0; k < n; k++)
      src_q.push_back((k == bad_k || bad_k < 0) ? (seq_t[k % 16] ^ bad_xor) : seq_t[k % 16]);
  endtask

  initial begin
    int n;
    int src_k;
    repeat (3) tick();
    cmp_en = 1;
    check("rst_state", state_a, 0);
    check("rst_ready", ready_a, 0);
    check("rst_rx", rx_a, 0);
    check("rst_expd", expd_a, 4'h2);
    #2 rst_n = 1'b1;
    tick();

    // 1: clean sequence, mode 0
    push_seq(16, 99, 4'h0);
    pulse_start();
    n = 0;
    while (src_q.size() > 0 && n < 100) begin tick(); n++; end
    check("t1_cycles", n, 16);
    check("t1_rx", rx_a, 16);
    check("t1_err", err_a, 0);
    check("t1_flag", flag_a, 0);
    check("t1_expd", expd_a, 4'h2);
    check("t1_order", (exp_q.size() >= 3) ? int'(exp_q[2]) : -1, 4'hd);

    // 2: third word wrong, no stop
    pulse_clear();
    push_seq(16, 2, 4'hd);
    pulse_start();
    n = 0;
    while (src_q.size() > 0 && n < 100) begin tick(); n++; end
    check("t2_err", err_a, 1);
    check("t2_flag", flag_a, 1);
    check("t2_first", first_a, 2);
    check("t2_rx", rx_a, 16);

    // 3: stop on fifth word
    pulse_clear();
    stop_on_error = 1'b1;
    push_seq(8, 4, 4'hf);
    pulse_start();
    repeat (10) tick();
    check("t3_rx", rx_a, 5);
    check("t3_state", state_a, 2);
    check("t3_ready", ready_a, 0);
    pulse_clear();
    stop_on_error = 1'b0;
    check("t3_clr_state", state_a, 0);
    check("t3_clr_rx", rx_a, 0);
    check("t3_clr_err", err_a, 0);
    check("t3_clr_flag", flag_a, 0);

    // 4: alternate ready
    ready_mode = 2'd3;
    push_seq(30, 99, 4'h0);
    pulse_start();
    repeat (20) tick();
    check("t4_rx", rx_a, 10);
    check("t4_err", err_a, 0);
    pulse_clear();

    // 5: LFSR ready, valid held for 1000 cycles
    ready_mode = 2'd2;
    push_seq(1010, 99, 4'h0);
    pulse_start();
    repeat (1000) tick();
    check("t5_rx", rx_a, m_rx % 256);
    check("t5_err", err_a, 0);
    pulse_clear();

    // random phase
    gap_en = 1;
    src_k = 0;
    for (int it = 0; it < 1500; it++) begin
      if ($urandom_range(0, 49) == 0) begin
        src_q.delete();
        src_k = 0;
        clear = 1'b1;
      end else clear = 1'b0;
      start = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 29) == 0) ready_mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 39) == 0) stop_on_error = ~stop_on_error;
      ext_ready = $urandom_range(0, 1);
      while (src_q.size() < 4) begin
        src_q.push_back(($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : seq_t[src_k % 16]);
        src_k++;
      end
      tick();
    end
    start = 1'b0;
    gap_en = 0;
    stop_on_error = 1'b0;
    ready_mode = 2'd0;
    pulse_clear();

    // 6: 300 wrong words -> saturation and wrap
    push_seq(300, -1, 4'h1);
    pulse_start();
    n = 0;
    while (src_q.size() > 0 && n < 400) begin tick(); n++; end
    check("t6_cycles", n, 300);
    check("t6_err_a", err_a, 255);
    check("t6_err_b", err_b, 15);
    check("t6_rx_a", rx_a, 44);
    check("t6_rx_b", rx_b, 12);
    check("t6_first", first_a, 0);
    check("t6_flag", flag_b, 1);

    // asynchronous reset mid-stream
    pulse_clear();
    push_seq(20, 99, 4'h0);
    pulse_start();
    repeat (5) tick();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("ar_ready_a", ready_a, 0);
    check("ar_ready_b", ready_b, 0);
    check("ar_state", state_a, 0);
    check("ar_rx", rx_a, 0);
    check("ar_last", last_a, 0);
    check("ar_expd", expd_a, 4'h2);
    src_q.delete();
    tick();
    tick();
    #2 rst_n = 1'b1;
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
